// File: rtl/regbus_pkg.sv
// Shared definitions for the register bus: initiator FSM states and default bus widths.
// The register-file generator output imports this same package.
package regbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/regbus_master.sv
// Register-bus initiator: one bus cycle per host request, with a read timeout
// and a saturating count of timed-out reads.
module regbus_master
  import regbus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TIMEOUT  = 16,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   addr,
  output logic                chip_select,
  output logic                write_en,
  output logic                read_en,
  output logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W-1:0]   read_data,
  input  logic                data_valid,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state;
  logic [CNT_W-1:0] to_cnt;

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where rsp_valid && rsp_ready. Once raised,
  // rsp_valid and rsp_* stay stable until that transfer happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      addr        <= '0;
      chip_select <= 1'b0;
      write_en    <= 1'b0;
      read_en     <= 1'b0;
      write_data  <= '0;
      busy        <= 1'b0;
      err_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            addr        <= req_addr;
            chip_select <= 1'b1;
            to_cnt      <= '0;
            if (req_write) begin
              write_en   <= 1'b1;
              write_data <= req_wdata;
              state      <= ST_WRITE;
            end else begin
              read_en <= 1'b1;
              state   <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          // The responder gives no write ack, so the single strobe cycle completes it.
          chip_select <= 1'b0;
          write_en    <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_rdata   <= '0;
          rsp_err     <= 1'b0;
          state       <= ST_RESP;
        end
        ST_READ: begin
          if (data_valid) begin
            chip_select <= 1'b0;
            read_en     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= read_data;
            rsp_err     <= 1'b0;
            state       <= ST_RESP;
          end else if (to_cnt == CNT_LAST) begin
            chip_select <= 1'b0;
            read_en     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
            state       <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbus_master.sv
// Directed bench for regbus_master against a small register-file responder model.
module tb_regbus_master;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int TIMEOUT  = 16;
  localparam int ERRCNT_W = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic                req_write = 1'b0;
  logic [ADDR_W-1:0]   req_addr = '0;
  logic [DATA_W-1:0]   req_wdata = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic [ADDR_W-1:0]   addr;
  logic                chip_select;
  logic                write_en;
  logic                read_en;
  logic [DATA_W-1:0]   write_data;
  logic [DATA_W-1:0]   read_data;
  logic                data_valid;
  logic                busy;
  logic [ERRCNT_W-1:0] err_count;

  int errors = 0;
  int checks = 0;

  // Responder model: writes on cs&we, data_valid one cycle after read active.
  logic [DATA_W-1:0] mem [0:255];
  logic              dv_model = 1'b0;
  logic              mute = 1'b0;
  logic              dv_inject = 1'b0;

  assign read_data  = (chip_select && read_en) ? mem[addr] : '0;
  assign data_valid = (dv_model && !mute) || dv_inject;

  always @(posedge clk) begin
    if (chip_select && write_en) mem[addr] <= write_data;
    dv_model <= chip_select && read_en && !dv_model;
  end

  always #5 clk = ~clk;

  regbus_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .ERRCNT_W(ERRCNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .chip_select(chip_select), .write_en(write_en), .read_en(read_en),
    .write_data(write_data), .read_data(read_data), .data_valid(data_valid),
    .busy(busy), .err_count(err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] rd,
                         output logic er);
    issue(1'b0, a, '0);
    wait_rsp();
    rd = rsp_rdata;
    er = rsp_err;
    take_rsp();
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic              er;
    int                n;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    #2;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_strobes", {29'd0, chip_select, write_en, read_en}, 32'd0);
    check("rst_addr", {24'd0, addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err_count", {30'd0, err_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1. Single write
    issue(1'b1, 8'h14, 32'hA5A5_0001);
    check("wr_strobes", {29'd0, chip_select, write_en, read_en}, 32'b110);
    check("wr_addr", {24'd0, addr}, 32'h14);
    check("wr_data", write_data, 32'hA5A5_0001);
    check("wr_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("wr_strobes_off", {29'd0, chip_select, write_en, read_en}, 32'd0);
    check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    take_rsp();
    check("wr_rsp_drop", {31'd0, rsp_valid}, 32'd0);
    check("wr_idle_busy", {31'd0, busy}, 32'd0);
    check("wr_mem", mem[8'h14], 32'hA5A5_0001);

    // 2. Read with a responsive slave: data_valid in READ cycle 2
    issue(1'b0, 8'h14, '0);
    check("rd_c1_strobes", {29'd0, chip_select, write_en, read_en}, 32'b101);
    check("rd_c1_dv", {31'd0, data_valid}, 32'd0);
    @(negedge clk);
    check("rd_c2_read_en", {31'd0, read_en}, 32'd1);
    check("rd_c2_dv", {31'd0, data_valid}, 32'd1);
    @(negedge clk);
    check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
    check("rd_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rd_strobes_off", {29'd0, chip_select, write_en, read_en}, 32'd0);
    take_rsp();

    // 3. Timeout: read_en high exactly TIMEOUT cycles, late data_valid ignored
    mute = 1'b1;
    issue(1'b0, 8'h20, '0);
    n = 0;
    while (read_en && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("to_read_cycles", n, 32'd16);
    check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("to_rsp_rdata", rsp_rdata, 32'd0);
    check("to_err_count", {30'd0, err_count}, 32'd1);
    dv_inject = 1'b1;
    @(negedge clk);
    dv_inject = 1'b0;
    check("late_dv_rdata", rsp_rdata, 32'd0);
    check("late_dv_err", {31'd0, rsp_err}, 32'd1);
    take_rsp();
    dv_inject = 1'b1;
    @(negedge clk);
    dv_inject = 1'b0;
    check("late_dv_idle_busy", {31'd0, busy}, 32'd0);
    check("late_dv_idle_re", {31'd0, read_en}, 32'd0);
    check("late_dv_err_count", {30'd0, err_count}, 32'd1);
    mute = 1'b0;

    // 4. Back-pressure on the response, then back-to-back write+read
    issue(1'b1, 8'h10, 32'h1234_5678);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_err_rdata", {rsp_err, rsp_rdata[30:0]}, 32'd0);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    take_rsp();
    check("b2b_mem10", mem[8'h10], 32'h1234_5678);
    do_read(8'h14, rd, er);
    check("b2b_rd14", rd, 32'hA5A5_0001);
    check("b2b_rd14_err", {31'd0, er}, 32'd0);
    do_read(8'h10, rd, er);
    check("b2b_rd10", rd, 32'h1234_5678);

    // 5. Reset during READ
    issue(1'b0, 8'h14, '0);
    check("rr_read_active", {31'd0, read_en}, 32'd1);
    rst = 1'b1;
    #1;
    check("rr_strobes", {29'd0, chip_select, write_en, read_en}, 32'd0);
    check("rr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rr_busy", {31'd0, busy}, 32'd0);
    check("rr_err_count", {30'd0, err_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_read(8'h14, rd, er);
    check("rr_after_rd", rd, 32'hA5A5_0001);
    check("rr_after_err", {31'd0, er}, 32'd0);

    // 6. Error counter saturation at 2'b11
    mute = 1'b1;
    do_read(8'h30, rd, er);
    check("sat_1", {30'd0, err_count}, 32'd1);
    do_read(8'h30, rd, er);
    check("sat_2", {30'd0, err_count}, 32'd2);
    do_read(8'h30, rd, er);
    check("sat_3", {30'd0, err_count}, 32'd3);
    do_read(8'h30, rd, er);
    check("sat_4", {30'd0, err_count}, 32'd3);
    check("sat_4_err", {31'd0, er}, 32'd1);
    mute = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
